// File: rtl/io_display_ctrl.sv
// io_display_ctrl
//   Memory-mapped IO peripheral sitting on the processor IO port. It drives an
//   NDIG-digit multiplexed active-low 7-segment display, with per-digit
//   blanking and a 16-level brightness duty. It also conditions SW_W switches
//   and one button (synchronise + debounce), and latches button presses in a
//   sticky PRESS flag.
//
//   Register map (IOAddr):
//     0x0 DISP  RW  digit k in [7k+6:7k]
//     0x4 SW    RO  {0, sw_db, 2'b00}
//     0x8 BTN   RW  read {0, PRESS, btn_db}; write bit1=1 clears PRESS
//     0xC CTRL  RW  [0]=EN, [4+:NDIG]=MASK (1=blank), [19:16]=DUTY
//
//   Ports:
//     CLK, RESET           system clock, async active-high reset
//     IOAddr/IOWriteData   word address and write data
//     IOWriteEn            one-cycle write strobe
//     IOReadData           combinational read data for IOAddr
//     SW_IN, BTN_IN        raw asynchronous board inputs
//     LED[6:0]             segments a..g, active-low, registered
//     AN[NDIG-1:0]         digit anodes, active-low, registered

module io_display_ctrl #(
    parameter int NDIG    = 4,
    parameter int DWELL_W = 14,
    parameter int SW_W    = 2,
    parameter int DB_W    = 16
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic [3:0]      IOAddr,
    input  logic [31:0]     IOWriteData,
    input  logic            IOWriteEn,
    output logic [31:0]     IOReadData,
    input  logic [SW_W-1:0] SW_IN,
    input  logic            BTN_IN,
    output logic [6:0]      LED,
    output logic [NDIG-1:0] AN
);
    localparam int IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;

    logic [7*NDIG-1:0]  disp;
    logic               en;
    logic [NDIG-1:0]    mask;
    logic [3:0]         duty;
    logic               press;
    logic [DWELL_W-1:0] dwell;
    logic [IDX_W-1:0]   idx;

    // bit SW_W is the button, bits below are the switches
    logic [SW_W:0] in_db;
    logic [SW_W:0] in_rise;
    logic [SW_W-1:0] sw_db;
    logic          btn_db;
    logic          btn_rise;

    logic wr_disp, wr_btn, wr_ctrl;
    logic on;
    logic unused_wdata;

    assign wr_disp = IOWriteEn && (IOAddr == 4'h0);
    assign wr_btn  = IOWriteEn && (IOAddr == 4'h8);
    assign wr_ctrl = IOWriteEn && (IOAddr == 4'hC);

    // one conditioning lane per input bit
    io_debounce #(.DB_W(DB_W)) u_db [SW_W:0] (
        .CLK  (CLK),
        .RESET(RESET),
        .din  ({BTN_IN, SW_IN}),
        .dout (in_db),
        .rise (in_rise)
    );

    assign sw_db    = in_db[SW_W-1:0];
    assign btn_db   = in_db[SW_W];
    assign btn_rise = in_rise[SW_W];

    // ------------------------------------------------------------------ regs
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            disp <= '0;
            en   <= 1'b1;
            mask <= '0;
            duty <= 4'hF;
        end else begin
            if (wr_disp) disp <= IOWriteData[7*NDIG-1:0];
            if (wr_ctrl) begin
                en   <= IOWriteData[0];
                mask <= IOWriteData[4 +: NDIG];
                duty <= IOWriteData[19:16];
            end
        end
    end

    // a new press in the same cycle as a clear keeps the flag set
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET)                           press <= 1'b0;
        else if (btn_rise)                   press <= 1'b1;
        else if (wr_btn && IOWriteData[1])   press <= 1'b0;
    end

    // ------------------------------------------------------------------ scan
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            dwell <= '0;
            idx   <= '0;
        end else begin
            dwell <= dwell + 1'b1;
            if (&dwell)
                idx <= (idx == IDX_W'(NDIG - 1)) ? '0 : idx + 1'b1;
        end
    end

    // brightness: digit is lit only while the top dwell nibble is <= DUTY
    assign on = en && !mask[idx] && (dwell[DWELL_W-1 -: 4] <= duty);

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            AN  <= '1;
            LED <= 7'h7F;
        end else if (on) begin
            AN  <= ~(NDIG'(1) << idx);
            LED <= ~disp[7*idx +: 7];
        end else begin
            AN  <= '1;
            LED <= 7'h7F;
        end
    end

    // ------------------------------------------------------------------ read
    always_comb begin
        IOReadData = '0;
        case (IOAddr)
            4'h0: IOReadData = 32'(disp);
            4'h4: IOReadData = 32'({sw_db, 2'b00});
            4'h8: IOReadData = {30'b0, press, btn_db};
            4'hC: begin
                IOReadData[0]        = en;
                IOReadData[4 +: NDIG] = mask;
                IOReadData[19:16]    = duty;
            end
            default: IOReadData = '0;
        endcase
    end

    assign unused_wdata = ^IOWriteData;

endmodule

// io_debounce
//   One input lane: 2-flop synchroniser followed by a debounce counter.
//   The counter runs only while the synced value differs from the accepted
//   one; at terminal count the new value is accepted. rise pulses in the
//   cycle whose edge accepts a 0->1 change.
//   Ports: CLK, RESET, din (raw), dout (debounced), rise (accept-high strobe)
module io_debounce #(
    parameter int DB_W = 16
) (
    input  logic CLK,
    input  logic RESET,
    input  logic din,
    output logic dout,
    output logic rise
);
    logic            s1, s2;
    logic [DB_W-1:0] cnt;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            s1   <= 1'b0;
            s2   <= 1'b0;
            cnt  <= '0;
            dout <= 1'b0;
        end else begin
            s1 <= din;
            s2 <= s1;
            if (s2 == dout) begin
                cnt <= '0;
            end else if (&cnt) begin
                dout <= s2;
                cnt  <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign rise = !dout && s2 && (&cnt);

endmodule

// File: tb/tb_io_display_ctrl.sv
// Bench for io_display_ctrl (NDIG=4, DWELL_W=4, SW_W=2, DB_W=3).
// Stimulus pushes expectations into a queue; a negedge monitor pops and
// compares whenever the stimulus flags that an output is ready to sample.
module tb_io_display_ctrl;
    logic        CLK, RESET;
    logic [3:0]  IOAddr;
    logic [31:0] IOWriteData;
    logic        IOWriteEn;
    logic [31:0] IOReadData;
    logic [1:0]  SW_IN;
    logic        BTN_IN;
    logic [6:0]  LED;
    logic [3:0]  AN;

    io_display_ctrl #(.NDIG(4), .DWELL_W(4), .SW_W(2), .DB_W(3)) dut (
        .CLK(CLK), .RESET(RESET), .IOAddr(IOAddr), .IOWriteData(IOWriteData),
        .IOWriteEn(IOWriteEn), .IOReadData(IOReadData), .SW_IN(SW_IN),
        .BTN_IN(BTN_IN), .LED(LED), .AN(AN)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct packed {
        logic        kind;   // 1: {AN,LED}, 0: IOReadData
        logic [31:0] val;
    } exp_t;

    exp_t        exp_q[$];
    string       name_q[$];
    int          n_chk = 0;
    int          n_pass = 0;
    bit          chk_req = 1'b0;
    int unsigned cyc;
    logic [27:0] disp_m;
    logic [31:0] ctrl_m;

    // edges seen since reset release
    always @(posedge CLK or posedge RESET)
        if (RESET) cyc <= 0;
        else       cyc <= cyc + 1;

    // ------------------------------------------------------------ monitor
    exp_t        mon_e;
    string       mon_n;
    logic [31:0] mon_act;
    always @(negedge CLK) begin
        if (chk_req) begin
            n_chk++;
            if (exp_q.size() == 0) begin
                $display("FAIL monitor: output presented with no expectation queued");
            end else begin
                mon_e   = exp_q.pop_front();
                mon_n   = name_q.pop_front();
                mon_act = mon_e.kind ? {21'b0, AN, LED} : IOReadData;
                if (mon_act === mon_e.val) n_pass++;
                else $display("FAIL %s: got %h expected %h (cyc %0d)", mon_n, mon_act, mon_e.val, cyc);
            end
        end
    end

    // expected {AN,LED} after the next edge, from the state after n edges
    function automatic logic [31:0] scan_exp(input int unsigned n, input logic [27:0] dm,
                                             input logic [31:0] cm);
        int unsigned d, i;
        logic [3:0]  an;
        logic [6:0]  led;
        d   = n % 16;
        i   = (n / 16) % 4;
        an  = 4'hF;
        led = 7'h7F;
        if (cm[0] && !cm[4+i] && (d <= 32'(cm[19:16]))) begin
            an  = ~(4'b0001 << i);
            led = ~dm[7*i +: 7];
        end
        return {21'b0, an, led};
    endfunction

    // ------------------------------------------------------------ tasks
    task automatic step(input int n);
        repeat (n) @(negedge CLK);
        #1;
    endtask

    task automatic expect_now(input logic kind, input logic [31:0] v, input string nm);
        exp_q.push_back(exp_t'{kind, v});
        name_q.push_back(nm);
        chk_req = 1'b1;
        @(negedge CLK);
        #1 chk_req = 1'b0;
    endtask

    task automatic chk_rd(input logic [3:0] a, input logic [31:0] v, input string nm);
        IOAddr = a;
        expect_now(1'b0, v, nm);
    endtask

    task automatic chk_scan(input string nm);
        expect_now(1'b1, scan_exp(cyc, disp_m, ctrl_m), nm);
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        IOAddr      = a;
        IOWriteData = d;
        IOWriteEn   = 1'b1;
        @(negedge CLK);
        #1 IOWriteEn = 1'b0;
        if (a == 4'h0) disp_m = d[27:0];
        if (a == 4'hC) ctrl_m = d & 32'h000F_00F1;
    endtask

    // ------------------------------------------------------------ stimulus
    initial begin
        RESET = 1'b1; IOAddr = 4'h0; IOWriteData = '0; IOWriteEn = 1'b0;
        SW_IN = 2'b00; BTN_IN = 1'b0;
        disp_m = '0; ctrl_m = 32'h000F_0001;
        step(2);
        expect_now(1'b1, 32'h0000_07FF, "rst_out");
        chk_rd(4'h0, 32'h0, "rst_disp");
        chk_rd(4'h4, 32'h0, "rst_sw");
        chk_rd(4'h8, 32'h0, "rst_btn");
        chk_rd(4'hC, 32'h000F_0001, "rst_ctrl");
        RESET = 1'b0;

        // digits 3..0 = 00,3F,17,3A -> LED 7F,40,68,45
        wr(4'h0, 32'h000F_CBBA);
        for (int k = 0; k < 64; k++) chk_scan("scan_full");
        chk_rd(4'h0, 32'h000F_CBBA, "disp_rd");

        // blank digits 0,2; duty 1/16
        wr(4'hC, 32'h0000_0051);
        chk_rd(4'hC, 32'h0000_0051, "ctrl_rd");
        for (int k = 0; k < 64; k++) chk_scan("scan_mask_duty0");
        wr(4'hC, 32'h000F_0001);

        // switch glitch of 5 cycles never accepted
        SW_IN = 2'b11; step(5); SW_IN = 2'b00;
        for (int k = 0; k < 12; k++) chk_rd(4'h4, 32'h0, "sw_glitch");
        SW_IN = 2'b11; step(12);
        chk_rd(4'h4, 32'h0000_000C, "sw_held");
        SW_IN = 2'b10; step(12);
        chk_rd(4'h4, 32'h0000_0008, "sw_bit1");
        SW_IN = 2'b00; step(12);
        chk_rd(4'h4, 32'h0, "sw_release");

        // button press / sticky flag
        BTN_IN = 1'b1; step(12);
        chk_rd(4'h8, 32'h3, "btn_held");
        BTN_IN = 1'b0; step(12);
        chk_rd(4'h8, 32'h2, "btn_released");
        wr(4'h8, 32'h1);
        chk_rd(4'h8, 32'h2, "btn_wr_bit0_only");
        wr(4'h8, 32'h2);
        chk_rd(4'h8, 32'h0, "btn_cleared");
        // debounce accepts on the 10th edge; the clear-write lands on it
        BTN_IN = 1'b1; step(9);
        wr(4'h8, 32'h2);
        chk_rd(4'h8, 32'h3, "btn_set_wins");
        BTN_IN = 1'b0; step(12);

        // decode: unmapped writes, write-enable low, unused CTRL bits
        wr(4'h5, 32'hFFFF_FFFF);
        chk_rd(4'h0, 32'h000F_CBBA, "bad_addr_disp");
        chk_rd(4'hC, 32'h000F_0001, "bad_addr_ctrl");
        chk_rd(4'h5, 32'h0, "bad_addr_rd");
        chk_rd(4'h8, 32'h2, "press_kept");
        IOAddr = 4'h0; IOWriteData = 32'h0123_4567; IOWriteEn = 1'b0; step(1);
        chk_rd(4'h0, 32'h000F_CBBA, "wen_low");
        wr(4'hC, 32'hFFFF_FFFF);
        chk_rd(4'hC, 32'h000F_00F1, "ctrl_unused");
        wr(4'hC, 32'h000F_0001);

        // reset while a digit is lit and a switch is mid-debounce
        SW_IN = 2'b11; step(5);
        RESET = 1'b1;
        disp_m = '0; ctrl_m = 32'h000F_0001;
        expect_now(1'b1, 32'h0000_07FF, "rst_mid_out");
        chk_rd(4'h0, 32'h0, "rst_mid_disp");
        chk_rd(4'h4, 32'h0, "rst_mid_sw");
        chk_rd(4'h8, 32'h0, "rst_mid_btn");
        chk_rd(4'hC, 32'h000F_0001, "rst_mid_ctrl");
        SW_IN = 2'b00;
        RESET = 1'b0;
        for (int k = 0; k < 20; k++) chk_scan("scan_after_rst");
        chk_rd(4'h4, 32'h0, "post_rst_sw");

        // drain scoreboard with a bounded wait
        for (int w = 0; w < 10 && exp_q.size() != 0; w++) @(negedge CLK);
        if (exp_q.size() != 0) begin
            n_chk++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
